// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : RV32M execute-stage unit: single-cycle multiply, radix-2
//            restoring divide/remainder over 32 iterations.
// Revision : 1.0  initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              CNT_W     = $clog2(XLEN);
    localparam logic [XLEN-1:0] C_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIV_RUN = 2'd1,
        S_DIV_FIN = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t          state_q,   state_d;
    logic [XLEN-1:0] result_q,  result_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    // dvd shifts the dividend out of its MSB while quotient bits enter its LSB
    logic [XLEN-1:0] dvd_q,     dvd_d;
    logic [XLEN-1:0] dvs_q,     dvs_d;
    logic [XLEN-1:0] rem_q,     rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            sel_rem_q, sel_rem_d;

    // ------------------------------------------------------------------
    // Multiply datapath
    // ------------------------------------------------------------------
    logic              w_a_signed;
    logic              w_b_signed;
    logic [2*XLEN-1:0] w_a_ext;
    logic [2*XLEN-1:0] w_b_ext;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;

    assign w_a_signed = (func3[1:0] != 2'b11);
    assign w_b_signed = (func3[1] == 1'b0);
    assign w_a_ext    = {{XLEN{w_a_signed & op_a[XLEN-1]}}, op_a};
    assign w_b_ext    = {{XLEN{w_b_signed & op_b[XLEN-1]}}, op_b};
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_mul_res  = (func3[1:0] == 2'b00) ? w_prod[XLEN-1:0]
                                              : w_prod[2*XLEN-1:XLEN];

    // ------------------------------------------------------------------
    // Divide setup and iteration
    // ------------------------------------------------------------------
    logic            w_div_signed;
    logic            w_div_by_zero;
    logic            w_div_ovf;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_abs;
    logic [XLEN-1:0] w_b_abs;
    logic [XLEN:0]   w_trial;
    logic            w_fits;
    logic [XLEN-1:0] w_rem_next;
    logic [XLEN-1:0] w_quo_fin;
    logic [XLEN-1:0] w_rem_fin;

    assign w_div_signed  = ~func3[0];
    assign w_div_by_zero = (op_b == '0);
    assign w_div_ovf     = w_div_signed && (op_a == C_INT_MIN) && (op_b == '1);
    assign w_a_neg       = w_div_signed & op_a[XLEN-1];
    assign w_b_neg       = w_div_signed & op_b[XLEN-1];
    assign w_a_abs       = w_a_neg ? -op_a : op_a;
    assign w_b_abs       = w_b_neg ? -op_b : op_b;

    // Partial remainder can reach 33 bits before the compare for unsigned divisors
    assign w_trial    = {rem_q, dvd_q[XLEN-1]};
    assign w_fits     = (w_trial >= {1'b0, dvs_q});
    assign w_rem_next = w_fits ? (w_trial[XLEN-1:0] - dvs_q) : w_trial[XLEN-1:0];

    assign w_quo_fin  = neg_quo_q ? -dvd_q : dvd_q;
    assign w_rem_fin  = neg_rem_q ? -rem_q : rem_q;

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        sel_rem_d = sel_rem_q;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_d = S_IDLE;
                    if (start) begin
                        if (!func3[2]) begin
                            result_d = w_mul_res;
                            state_d  = S_DONE;
                        end else if (w_div_by_zero) begin
                            result_d = func3[1] ? op_a : '1;
                            state_d  = S_DONE;
                        end else if (w_div_ovf) begin
                            result_d = func3[1] ? '0 : C_INT_MIN;
                            state_d  = S_DONE;
                        end else begin
                            dvd_d     = w_a_abs;
                            dvs_d     = w_b_abs;
                            rem_d     = '0;
                            neg_quo_d = w_a_neg ^ w_b_neg;
                            neg_rem_d = w_a_neg;
                            sel_rem_d = func3[1];
                            cnt_d     = CNT_W'(XLEN-1);
                            state_d   = S_DIV_RUN;
                        end
                    end
                end
                S_DIV_RUN: begin
                    rem_d = w_rem_next;
                    dvd_d = {dvd_q[XLEN-2:0], w_fits};
                    if (cnt_q == '0) begin
                        state_d = S_DIV_FIN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_DIV_FIN: begin
                    result_d = sel_rem_q ? w_rem_fin : w_quo_fin;
                    state_d  = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            sel_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            sel_rem_q <= sel_rem_d;
        end
    end

    assign busy   = (state_q == S_DIV_RUN) || (state_q == S_DIV_FIN);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Self-checking bench for muldiv_unit (vector table, corner
//            sequences, randomized ops against an arithmetic reference).
// Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic        flush  = 1'b0;
    logic [2:0]  func3  = 3'd0;
    logic [31:0] op_a   = 32'd0;
    logic [31:0] op_b   = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .flush  (flush),
        .func3  (func3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model: plain 64-bit arithmetic on the RV32M rules
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        p   = 64'd0;
        r   = 32'd0;
        case (f)
            3'd0: begin p = sa * sb; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFFFFFF;
                else if (ovf) r = 32'h80000000;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: begin
                if (b == 0) r = 32'hFFFFFFFF;
                else begin p = ua / ub; r = p[31:0]; end
            end
            3'd6: begin
                if (b == 0) r = a;
                else if (ovf) r = 32'd0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: begin
                if (b == 0) r = a;
                else begin p = ua % ub; r = p[31:0]; end
            end
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return 1;
        if (b == 0) return 1;
        if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 34;
    endfunction

    // mode 0: plain; 1: scramble operands while busy; 2: pulse start (MUL) mid-divide
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int mode, output logic [31:0] res, output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; func3 = f; op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        bcnt  = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            if (mode == 1 && busy) begin
                op_a  = $urandom;
                op_b  = $urandom;
                func3 = 3'($urandom);
            end
            if (mode == 2) begin
                start = (lat == 5);
                if (lat == 5) begin
                    func3 = 3'b000; op_a = 32'd3; op_b = 32'd3;
                end
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        res   = result;
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        int          mode;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic [31:0] r;
        int          lat, bcnt;
        logic        saw;

        vecs[0]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1,  0};
        vecs[1]  = '{3'b000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1,  0};
        vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1,  0};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1,  0};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34, 1};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34, 1};
        vecs[6]  = '{3'b101, 32'd100,      32'd0,        32'hFFFFFFFF, 1,  0};
        vecs[7]  = '{3'b111, 32'd100,      32'd0,        32'd100,      1,  0};
        vecs[8]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0};
        vecs[9]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  0};
        vecs[10] = '{3'b101, 32'd1000,     32'd7,        32'd142,      34, 0};
        vecs[11] = '{3'b111, 32'd1000,     32'd7,        32'd6,        34, 0};
        vecs[12] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, 0};
        vecs[13] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 34, 0};
        vecs[14] = '{3'b100, 32'd100,      32'd7,        32'd14,       34, 2};
        vecs[15] = '{3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34, 0};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_busy",   32'(busy),   32'd0);
        check("reset_done",   32'(done),   32'd0);
        check("reset_result", result,      32'd0);
        rst_n = 1'b1;

        // Directed vector table
        foreach (vecs[i]) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].mode, r, lat, bcnt);
            check($sformatf("vec%0d_result", i), r, vecs[i].res);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), (vecs[i].lat == 34) ? 32'd33 : 32'd0);
            @(negedge clk);
            check($sformatf("vec%0d_done_one_cycle", i), 32'(done), 32'd0);
        end

        // Flush mid-divide: no done, result held
        run_op(3'b000, 32'd6, 32'd7, 0, r, lat, bcnt);
        check("flush_prior_result", r, 32'd42);
        @(negedge clk);
        start = 1'b1; func3 = 3'b100; op_a = 32'd1000; op_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy",   32'(busy), 32'd0);
        check("flush_done",   32'(done), 32'd0);
        check("flush_result", result,    32'd42);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        check("flush_no_done", 32'(saw), 32'd0);

        // start together with flush is dropped
        start = 1'b1; flush = 1'b1; func3 = 3'b000; op_a = 32'd3; op_b = 32'd5;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_done",   32'(done), 32'd0);
        check("flush_start_result", result,    32'd42);

        run_op(3'b101, 32'd1000, 32'd7, 0, r, lat, bcnt);
        check("post_flush_result",  r,          32'd142);
        check("post_flush_latency", 32'(lat),   32'd34);

        // Reset mid-divide
        @(negedge clk);
        start = 1'b1; func3 = 3'b100; op_a = 32'd5000; op_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset_busy",   32'(busy), 32'd0);
        check("midreset_done",   32'(done), 32'd0);
        check("midreset_result", result,    32'd0);

        // Back-to-back multiplies with no idle gap
        @(negedge clk);
        start = 1'b1; func3 = 3'b000; op_a = 32'd6; op_b = 32'd7;
        @(negedge clk);
        check("b2b_done1",   32'(done), 32'd1);
        check("b2b_result1", result,    32'd42);
        op_a = 32'd9; op_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        check("b2b_done2",   32'(done), 32'd1);
        check("b2b_result2", result,    32'd81);
        @(negedge clk);
        check("b2b_idle",    32'(done), 32'd0);

        // Randomized ops against the reference model
        for (int k = 0; k < 150; k++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            int          sel;
            f   = 3'($urandom);
            sel = $urandom_range(0, 7);
            a   = $urandom;
            b   = $urandom;
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            else if (sel == 2) begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
            else if (sel == 3) b = $urandom_range(1, 5) * (($urandom & 1) ? 32'hFFFFFFFF : 32'd1);
            run_op(f, a, b, 0, r, lat, bcnt);
            check($sformatf("rand%0d_f%0d_%h_%h_result", k, f, a, b), r, ref_res(f, a, b));
            check($sformatf("rand%0d_latency", k), 32'(lat), 32'(ref_lat(f, a, b)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
